// File: rtl/ccd_capture_pkg.sv
// Shared types for the CCD capture front-end: FSM state encoding and ROI window payload.
package ccd_capture_pkg;

  // ROI fields are carried at this width; CNT_W of the users must not exceed it.
  localparam int unsigned ROI_CW = 16;

  typedef logic [1:0] cap_state_t;
  localparam cap_state_t IDLE     = 2'd0;
  localparam cap_state_t WAIT_SOF = 2'd1;
  localparam cap_state_t ACTIVE   = 2'd2;

  typedef struct packed {
    logic [ROI_CW-1:0] x0;
    logic [ROI_CW-1:0] y0;
    logic [ROI_CW-1:0] w;
    logic [ROI_CW-1:0] h;
  } roi_t;

endpackage

// File: rtl/ccd_roi_window.sv
// Per-frame shadow of ROI/line-width/mode settings plus the combinational window compare.
module ccd_roi_window
  import ccd_capture_pkg::*;
#(
  parameter int unsigned CNT_W = 11
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iLatch,
  input  roi_t             iRoi,
  input  logic [CNT_W-1:0] iLineW,
  input  logic             iSingle,
  input  logic [CNT_W-1:0] iFx,
  input  logic [CNT_W-1:0] iFy,
  output logic [CNT_W-1:0] oLineW,
  output logic             oSingle,
  output logic             oInRoi_c,
  output logic             oEolHit_c,
  output logic             oFullW_c,
  output logic [CNT_W-1:0] oRelX_c,
  output logic [CNT_W-1:0] oRelY_c
);

  // One extra bit so origin + size never wraps.
  localparam int unsigned CW = ROI_CW + 1;

  roi_t          roiSh;
  logic [CW-1:0] fxE, fyE, xEnd, yEnd;
  logic          inX, inY;

  // Settings are frozen at start of frame so mid-frame register writes cannot tear a frame.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      roiSh   <= '0;
      oLineW  <= '0;
      oSingle <= 1'b0;
    end else if (iLatch) begin
      roiSh   <= iRoi;
      oLineW  <= iLineW;
      oSingle <= iSingle;
    end
  end

  always_comb begin
    fxE       = CW'(iFx);
    fyE       = CW'(iFy);
    xEnd      = CW'(roiSh.x0) + CW'(roiSh.w);
    yEnd      = CW'(roiSh.y0) + CW'(roiSh.h);
    inX       = (fxE >= CW'(roiSh.x0)) && ((roiSh.w == '0) || (fxE < xEnd));
    inY       = (fyE >= CW'(roiSh.y0)) && ((roiSh.h == '0) || (fyE < yEnd));
    oInRoi_c  = inX && inY;
    oFullW_c  = (roiSh.w == '0);
    oEolHit_c = !oFullW_c && (fxE == (xEnd - CW'(1)));
    oRelX_c   = CNT_W'(fxE - CW'(roiSh.x0));
    oRelY_c   = CNT_W'(fyE - CW'(roiSh.y0));
  end

endmodule

// File: rtl/ccd_capture_roi.sv
// Camera pixel-bus capture: arm/disarm, single-shot, measured line length, ROI crop.
// With ROI width 0 the line end is only visible when iLVAL drops, so oEOL then trails the last beat by one cycle.
module ccd_capture_roi
  import ccd_capture_pkg::*;
#(
  parameter int unsigned DATA_W      = 10,
  parameter int unsigned CNT_W       = 11,
  parameter int unsigned FRAME_CNT_W = 32
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic [DATA_W-1:0]      iDATA,
  input  logic                   iFVAL,
  input  logic                   iLVAL,
  input  logic                   iSTART,
  input  logic                   iEND,
  input  logic                   iSINGLE,
  input  logic [CNT_W-1:0]       iLINE_W,
  input  logic [CNT_W-1:0]       iROI_X0,
  input  logic [CNT_W-1:0]       iROI_Y0,
  input  logic [CNT_W-1:0]       iROI_W,
  input  logic [CNT_W-1:0]       iROI_H,
  output logic [DATA_W-1:0]      oDATA,
  output logic                   oDVAL,
  output logic [CNT_W-1:0]       oX_Cont,
  output logic [CNT_W-1:0]       oY_Cont,
  output logic                   oSOF,
  output logic                   oEOL,
  output logic [FRAME_CNT_W-1:0] oFrame_Cont,
  output logic                   oBusy,
  output logic                   oLineErr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  cap_state_t       state, stateNext;
  logic             armed, armedNext, autoDisarm, latch;
  logic             preFval, preLval, rise, fall, lvalFall;
  logic [CNT_W-1:0] fx, fy, fxNext, fyNext;
  logic             lineErrSet, sofPend;
  logic             dvalNext, eolNext, sofNext;
  roi_t             roiIn;
  logic [CNT_W-1:0] lineWSh, relX, relY;
  logic             singleSh, inRoi, eolHit, fullW;

  assign rise     = !preFval && iFVAL;
  assign fall     = preFval && !iFVAL;
  assign lvalFall = preLval && !iLVAL;

  always_comb begin
    roiIn    = '0;
    roiIn.x0 = ROI_CW'(iROI_X0);
    roiIn.y0 = ROI_CW'(iROI_Y0);
    roiIn.w  = ROI_CW'(iROI_W);
    roiIn.h  = ROI_CW'(iROI_H);
  end

  ccd_roi_window #(.CNT_W(CNT_W)) u_win (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iLatch   (latch),
    .iRoi     (roiIn),
    .iLineW   (iLINE_W),
    .iSingle  (iSINGLE),
    .iFx      (fx),
    .iFy      (fy),
    .oLineW   (lineWSh),
    .oSingle  (singleSh),
    .oInRoi_c (inRoi),
    .oEolHit_c(eolHit),
    .oFullW_c (fullW),
    .oRelX_c  (relX),
    .oRelY_c  (relY)
  );

  // Next-state logic; frames are only entered on a clean FVAL rise.
  always_comb begin
    stateNext  = state;
    latch      = 1'b0;
    autoDisarm = 1'b0;
    case (state)
      IDLE: begin
        if (armed) stateNext = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (!armed) begin
          stateNext = IDLE;
        end else if (rise) begin
          stateNext = ACTIVE;
          latch     = 1'b1;
        end
      end
      ACTIVE: begin
        if (fall) begin
          if (singleSh || !armed) begin
            stateNext  = IDLE;
            autoDisarm = 1'b1;
          end else begin
            stateNext = WAIT_SOF;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    armedNext = armed;
    if (iEND)            armedNext = 1'b0;
    else if (iSTART)     armedNext = 1'b1;
    else if (autoDisarm) armedNext = 1'b0;
  end

  // Pixel/line counters and line-length check; FVAL falling mid-line is a truncated line.
  always_comb begin
    fxNext     = fx;
    fyNext     = fy;
    lineErrSet = 1'b0;
    if (state == ACTIVE) begin
      if (fall) begin
        fxNext = '0;
        fyNext = '0;
        if (lineWSh != '0) begin
          if (iLVAL)                         lineErrSet = 1'b1;
          else if (preLval && fx != lineWSh) lineErrSet = 1'b1;
        end
      end else if (iLVAL) begin
        fxNext = (fx == CNT_MAX) ? fx : fx + CNT_W'(1);
      end else if (preLval) begin
        fxNext = '0;
        fyNext = (fy == CNT_MAX) ? fy : fy + CNT_W'(1);
        if (lineWSh != '0 && fx != lineWSh) lineErrSet = 1'b1;
      end
    end else begin
      fxNext = '0;
      fyNext = '0;
    end
  end

  always_comb begin
    dvalNext = (state == ACTIVE) && iLVAL && inRoi;
    sofNext  = dvalNext && sofPend;
    eolNext  = (dvalNext && eolHit && !fall) ||
               (fullW && oDVAL && (state == ACTIVE) && lvalFall);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state       <= IDLE;
      armed       <= 1'b0;
      preFval     <= 1'b0;
      preLval     <= 1'b0;
      fx          <= '0;
      fy          <= '0;
      sofPend     <= 1'b0;
      oDATA       <= '0;
      oDVAL       <= 1'b0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
      oSOF        <= 1'b0;
      oEOL        <= 1'b0;
      oFrame_Cont <= '0;
      oBusy       <= 1'b0;
      oLineErr    <= 1'b0;
    end else begin
      state   <= stateNext;
      armed   <= armedNext;
      preFval <= iFVAL;
      preLval <= iLVAL;
      fx      <= fxNext;
      fy      <= fyNext;
      if (latch)         sofPend <= 1'b1;
      else if (dvalNext) sofPend <= 1'b0;
      oDATA <= iDATA;
      oDVAL <= dvalNext;
      if (dvalNext) begin
        oX_Cont <= relX;
        oY_Cont <= relY;
      end
      oSOF  <= sofNext;
      oEOL  <= eolNext;
      oBusy <= (stateNext == ACTIVE);
      if (latch) oFrame_Cont <= oFrame_Cont + FRAME_CNT_W'(1);
      if (lineErrSet)  oLineErr <= 1'b1;
      else if (iSTART) oLineErr <= 1'b0;
    end
  end

endmodule

// File: doc/ccd_capture_roi.md
Name: ccd_capture_roi

Overview:
Parametrised sensor capture front-end between the camera pixel bus (FVAL/LVAL/DATA) and the downstream Bayer/RGB conversion and recognition pipeline. It arms and disarms frame capture, and supports continuous or single-shot mode. Line length is measured from LVAL rather than a fixed constant. A runtime region-of-interest (ROI) window crops the output, and short/long lines are flagged. All outputs are registered with 1-cycle latency.

Parameters:
DATA_W, 10, pixel data width
CNT_W, 11, width of X/Y counters and ROI/line-width inputs
FRAME_CNT_W, 32, width of accepted-frame counter

Ports:
iCLK  in  1  pixel clock
iRST  in  1  asynchronous reset, active-high
iDATA  in  DATA_W  sensor pixel data
iFVAL  in  1  frame valid
iLVAL  in  1  line valid
iSTART  in  1  pulse: arm capture
iEND  in  1  pulse: disarm capture
iSINGLE  in  1  1 = single-shot mode: disarm automatically after one frame
iLINE_W  in  CNT_W  expected pixels per line (for error check)
iROI_X0, iROI_Y0  in  CNT_W  ROI origin (frame coordinates)
iROI_W, iROI_H  in  CNT_W  ROI size; 0 = full line/frame
oDATA  out  DATA_W  registered pixel
oDVAL  out  1  pixel valid and inside ROI
oX_Cont, oY_Cont  out  CNT_W  ROI-relative coordinates of oDATA
oSOF  out  1  one-cycle pulse with first ROI pixel of frame
oEOL  out  1  one-cycle pulse with last ROI pixel of a line
oFrame_Cont  out  FRAME_CNT_W  accepted-frame count, wraps
oBusy  out  1  frame capture in progress
oLineErr  out  1  sticky line-length error; cleared by iSTART

Behaviour:
- Reset (iRST=1, async): all outputs 0, all counters 0, state IDLE, armed=0, Pre_FVAL=0.
- Edge detection: Pre_FVAL is iFVAL delayed by 1 cycle. rise = !Pre_FVAL&iFVAL; fall = Pre_FVAL&!iFVAL.
- Arming: iSTART sets armed and clears oLineErr. iEND clears armed. If both occur in the same cycle, iEND wins.
- State machine:
  - IDLE: wait for armed; then go to WAIT_SOF. If iFVAL is already high when arming, wait for the next rise (never capture a partial frame).
  - WAIT_SOF: on rise with armed=1, go to ACTIVE, oFrame_Cont+1, and latch iLINE_W and the ROI inputs into shadow registers. If armed drops, return to IDLE.
  - ACTIVE: oBusy=1. On fall: if iSINGLE(latched) or !armed, go to IDLE and clear armed; otherwise go to WAIT_SOF.
  - iEND mid-frame: the current frame completes; no further frames are accepted.
- Counters (ACTIVE only): fx increments per cycle with iLVAL=1. On LVAL falling edge (registered LVAL=1, iLVAL=0): fx resets to 0, fy increments, and a line-length check runs. Both counters are 0 in IDLE/WAIT_SOF.
- Counter saturation: fx and fy saturate at 2^CNT_W-1 (no wrap).
- Line check: if shadow LINE_W≠0 and the completed length≠LINE_W, set oLineErr. oLineErr is sticky until iSTART or reset.
- ROI: in_roi = X0≤fx<X0+W and Y0≤fy<Y0+H, with W=0 / H=0 meaning unbounded. Compare at CNT_W+1 bits so X0+W does not overflow.
- Output stage (1-cycle latency):
  - oDATA = iDATA from the previous cycle (always).
  - oDVAL = ACTIVE & iLVAL & in_roi.
  - oX_Cont = fx-X0 and oY_Cont = fy-Y0, held when oDVAL=0.
  - oSOF = first oDVAL of a frame.
  - oEOL = oDVAL & (fx==X0+W-1, or, when W=0, the next cycle LVAL drops — W=0 EOL is asserted on the output beat when iLVAL falls).
- Frame cut short: fall during an active line ends the frame. The partial line is counted as a line error if LINE_W≠0. No oEOL is generated.
- Reset mid-frame: immediate return to IDLE; oFrame_Cont clears.

Decomposition:
- Package ccd_capture_pkg: typedef enum {IDLE, WAIT_SOF, ACTIVE} cap_state_t; struct roi_t {x0,y0,w,h}.
- Optional sub-module ccd_roi_window (combinational in_roi/EOL compare plus shadow registers).
- Everything else is flat.

Test Plan:
- Basic capture: iSTART, 4 lines×8 px frame, ROI all zero, iLINE_W=8 -> 32 oDVAL beats, data delayed 1 cycle, oX 0..7, oY 0..3, oFrame_Cont=1, oLineErr=0.
- ROI crop: X0=2, W=3, Y0=1, H=2 on 4×8 frame -> 6 beats, oX 0..2, oY 0..1, oSOF on first beat, oEOL on oX=2 beats.
- Single-shot: iSINGLE=1, three back-to-back frames -> only the first captured, oFrame_Cont=1, oBusy low after first fall.
- Mid-frame arm: iSTART while iFVAL=1 -> no oDVAL until the next rise; iSTART+iEND in the same cycle -> stays IDLE.
- Line error: iLINE_W=8, one line of 7 px -> oLineErr=1 persists over later good frames; next iSTART clears it.
- Async reset during ACTIVE line -> outputs 0 immediately; the next frame requires a new iSTART.
